// File: rtl/zorro_pkg.sv
// Shared types and constants for the Zorro bus master.
package zorro_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ASSERT,
        S_WAIT,
        S_DATA,
        S_TERM
    } state_t;

    localparam int DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/bus_watchdog.sv
// Counts consecutive cycles while clear is low; expired flags the last allowed cycle.
module bus_watchdog #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] counter;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            counter <= '0;
        end else if (!expired) begin
            counter <= counter + 1'b1;
        end
    end

    assign expired = !clear && (counter == CW'(LIMIT - 1));

endmodule

// File: rtl/zorro_master.sv
// Zorro bus master: one request runs ADDR/ASSERT/WAIT/DATA/TERM with registered bus outputs.
// Define ZORRO_MASTER_TIMEOUT_EN to abort WAIT after TIMEOUT_CYCLES with err.
module zorro_master
    import zorro_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        req,
    input  logic [22:0] req_addr,
    input  logic        req_rw,
    input  logic        req_ube,
    input  logic        req_lbe,
    input  logic [15:0] req_wdata,
    input  logic        bus_grant,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] rdata,
    output logic [22:0] ADDR,
    output logic        RW,
    output logic        AS_n,
    output logic        UDS_n,
    output logic        LDS_n,
    output logic [15:0] DOUT,
    output logic        DOE,
    input  logic [15:0] DIN,
    input  logic        DTACK_n,
    input  logic        BERR_n
);

    state_t      state, next_state;
    logic [22:0] addr_q;
    logic        rw_q, ube_q, lbe_q;
    logic [15:0] wdata_q;
    logic        dtack_q, berr_q;
    logic        err_flag;
    logic        timeout;
    logic        accept, no_enables;

    assign accept     = (state == S_IDLE) && req && bus_grant;
    assign no_enables = !req_ube && !req_lbe;

`ifdef ZORRO_MASTER_TIMEOUT_EN
    bus_watchdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (CLK),
        .reset  (RESET),
        .clear  (state != S_WAIT),
        .expired(timeout)
    );
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
    assign timeout        = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // DTACK_n/BERR_n are asynchronous, so the FSM only ever looks at their registered copies.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            addr_q   <= '0;
            rw_q     <= 1'b1;
            ube_q    <= 1'b0;
            lbe_q    <= 1'b0;
            wdata_q  <= '0;
            err_flag <= 1'b0;
            dtack_q  <= 1'b1;
            berr_q   <= 1'b1;
        end else begin
            dtack_q <= DTACK_n;
            berr_q  <= BERR_n;
            if (accept) begin
                addr_q   <= req_addr;
                rw_q     <= req_rw;
                ube_q    <= req_ube;
                lbe_q    <= req_lbe;
                wdata_q  <= req_wdata;
                err_flag <= no_enables;
            end else if (state == S_WAIT) begin
                if (!berr_q || (dtack_q && timeout)) begin
                    err_flag <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (accept) next_state = no_enables ? S_TERM : S_ADDR;
            S_ADDR:   next_state = S_ASSERT;
            S_ASSERT: next_state = S_WAIT;
            S_WAIT: begin
                if (!berr_q) begin
                    next_state = S_TERM;
                end else if (!dtack_q) begin
                    next_state = S_DATA;
                end else if (timeout) begin
                    next_state = S_TERM;
                end
            end
            S_DATA:   next_state = S_TERM;
            S_TERM:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // Bus and handshake outputs are decoded from the current state and registered,
    // so every pin changes one cycle after the state it belongs to.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            AS_n  <= 1'b1;
            UDS_n <= 1'b1;
            LDS_n <= 1'b1;
            RW    <= 1'b1;
            DOE   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
            ADDR  <= '0;
            DOUT  <= '0;
        end else begin
            busy  <= (state != S_IDLE);
            done  <= 1'b0;
            AS_n  <= 1'b1;
            UDS_n <= 1'b1;
            LDS_n <= 1'b1;
            case (state)
                S_IDLE: begin
                    DOE <= 1'b0;
                    if (accept) err <= 1'b0;
                end
                S_ADDR: begin
                    ADDR <= addr_q;
                    RW   <= rw_q;
                end
                S_ASSERT: begin
                    AS_n <= 1'b0;
                    if (rw_q) begin
                        UDS_n <= !ube_q;
                        LDS_n <= !lbe_q;
                    end else begin
                        DOE  <= 1'b1;
                        DOUT <= wdata_q;
                    end
                end
                S_WAIT, S_DATA: begin
                    AS_n  <= 1'b0;
                    UDS_n <= !ube_q;
                    LDS_n <= !lbe_q;
                    if (state == S_DATA && rw_q) rdata <= DIN;
                end
                S_TERM: begin
                    done <= 1'b1;
                    err  <= err_flag;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_zorro_master.sv
// Directed self-checking bench for zorro_master; each feature has its own test_* task.
module tb_zorro_master;

    logic        CLK;
    logic        RESET;
    logic        req;
    logic [22:0] req_addr;
    logic        req_rw;
    logic        req_ube;
    logic        req_lbe;
    logic [15:0] req_wdata;
    logic        bus_grant;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] rdata;
    logic [22:0] ADDR;
    logic        RW;
    logic        AS_n;
    logic        UDS_n;
    logic        LDS_n;
    logic [15:0] DOUT;
    logic        DOE;
    logic [15:0] DIN;
    logic        DTACK_n;
    logic        BERR_n;

    int checks = 0;
    int passed = 0;

    zorro_master dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .req      (req),
        .req_addr (req_addr),
        .req_rw   (req_rw),
        .req_ube  (req_ube),
        .req_lbe  (req_lbe),
        .req_wdata(req_wdata),
        .bus_grant(bus_grant),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .rdata    (rdata),
        .ADDR     (ADDR),
        .RW       (RW),
        .AS_n     (AS_n),
        .UDS_n    (UDS_n),
        .LDS_n    (LDS_n),
        .DOUT     (DOUT),
        .DOE      (DOE),
        .DIN      (DIN),
        .DTACK_n  (DTACK_n),
        .BERR_n   (BERR_n)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation still running, required finish");
        $fatal(1, "[TB] bench did not terminate");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present one request and drop req right after the accept edge.
    task automatic applyStimulus(input logic rw, input logic [22:0] a, input logic u,
                                 input logic l, input logic [15:0] wd);
        req_rw    = rw;
        req_addr  = a;
        req_ube   = u;
        req_lbe   = l;
        req_wdata = wd;
        req       = 1'b1;
        tick();
        req       = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        tick();
        tick();
        checks++;
        if ({AS_n, UDS_n, LDS_n, RW, DOE, busy, done, err} !== 8'b11110000)
            $display("[TB] FAIL reset_ctrl: got %b required 11110000",
                     {AS_n, UDS_n, LDS_n, RW, DOE, busy, done, err});
        else passed++;
        checks++;
        if (rdata !== 16'h0) $display("[TB] FAIL reset_rdata: got %h required 0000", rdata);
        else passed++;
        checks++;
        if (ADDR !== 23'h0) $display("[TB] FAIL reset_addr: got %h required 0", ADDR);
        else passed++;
        checks++;
        if (DOUT !== 16'h0) $display("[TB] FAIL reset_dout: got %h required 0000", DOUT);
        else passed++;
        RESET = 1'b0;
        tick();
    endtask

    task automatic test_read();
        logic [4:0] exp_vec [6] = '{5'b11100, 5'b00000, 5'b00000, 5'b00000, 5'b11101, 5'b11100};
        DIN     = 16'hA5C3;
        DTACK_n = 1'b0;
        BERR_n  = 1'b1;
        applyStimulus(1'b1, 23'h740000, 1'b1, 1'b1, 16'h0000);
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++;
            if ({AS_n, UDS_n, LDS_n, DOE, done} !== exp_vec[k-1])
                $display("[TB] FAIL read_pins k=%0d: got %b required %b", k,
                         {AS_n, UDS_n, LDS_n, DOE, done}, exp_vec[k-1]);
            else passed++;
            if (k == 1) begin
                checks++;
                if (ADDR !== 23'h740000) $display("[TB] FAIL read_addr: got %h required 740000", ADDR);
                else passed++;
                checks++;
                if ({RW, busy} !== 2'b11) $display("[TB] FAIL read_rw_busy: got %b required 11", {RW, busy});
                else passed++;
            end
            if (k == 5) begin
                checks++;
                if (rdata !== 16'hA5C3) $display("[TB] FAIL read_rdata: got %h required a5c3", rdata);
                else passed++;
                checks++;
                if (err !== 1'b0) $display("[TB] FAIL read_err: got %b required 0", err);
                else passed++;
            end
        end
    endtask

    task automatic test_write();
        logic [4:0] exp_vec [6] = '{5'b11100, 5'b01110, 5'b00110, 5'b00110, 5'b11111, 5'b11100};
        DIN     = 16'h0F0F;
        DTACK_n = 1'b0;
        applyStimulus(1'b0, 23'h748001, 1'b1, 1'b0, 16'h1234);
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++;
            if ({AS_n, UDS_n, LDS_n, DOE, done} !== exp_vec[k-1])
                $display("[TB] FAIL write_pins k=%0d: got %b required %b", k,
                         {AS_n, UDS_n, LDS_n, DOE, done}, exp_vec[k-1]);
            else passed++;
            if (k == 1) begin
                checks++;
                if ({ADDR, RW} !== {23'h748001, 1'b0})
                    $display("[TB] FAIL write_addr_rw: got %h/%b required 748001/0", ADDR, RW);
                else passed++;
            end
            if (k == 2) begin
                checks++;
                if (DOUT !== 16'h1234) $display("[TB] FAIL write_dout: got %h required 1234", DOUT);
                else passed++;
            end
            if (k == 5) begin
                checks++;
                if ({err, rdata} !== {1'b0, 16'hA5C3})
                    $display("[TB] FAIL write_err_rdata: got %b/%h required 0/a5c3", err, rdata);
                else passed++;
            end
        end
    endtask

    task automatic test_berr();
        int done_k = -1;
        logic err_at_done = 1'b0;
        DTACK_n = 1'b0;
        BERR_n  = 1'b0;
        DIN     = 16'hFFFF;
        applyStimulus(1'b1, 23'h000100, 1'b1, 1'b1, 16'h0000);
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (done && done_k < 0) begin
                done_k      = k;
                err_at_done = err;
            end
        end
        checks++;
        if (done_k !== 4) $display("[TB] FAIL berr_done_cycle: got %0d required 4", done_k);
        else passed++;
        checks++;
        if (err_at_done !== 1'b1) $display("[TB] FAIL berr_err: got %b required 1", err_at_done);
        else passed++;
        checks++;
        if (rdata !== 16'hA5C3) $display("[TB] FAIL berr_rdata: got %h required a5c3", rdata);
        else passed++;
        BERR_n = 1'b1;
    endtask

    task automatic test_no_enables();
        logic as_low = 1'b0;
        DTACK_n = 1'b0;
        applyStimulus(1'b1, 23'h000200, 1'b0, 1'b0, 16'h0000);
        tick();
        checks++;
        if ({done, err} !== 2'b11) $display("[TB] FAIL noen_done_err: got %b required 11", {done, err});
        else passed++;
        as_low = !AS_n;
        for (int k = 2; k <= 5; k++) begin
            tick();
            if (!AS_n) as_low = 1'b1;
        end
        checks++;
        if ({as_low, busy, done} !== 3'b000)
            $display("[TB] FAIL noen_idle: got %b required 000", {as_low, busy, done});
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [12:0] done_mask = '0;
        logic        as_low = 1'b0;
        int          done_count = 0;
        DTACK_n   = 1'b0;
        DIN       = 16'h5A5A;
        req_rw    = 1'b1;
        req_addr  = 23'h000300;
        req_ube   = 1'b1;
        req_lbe   = 1'b1;
        req_wdata = 16'h0000;
        req       = 1'b1;
        tick();
        checks++;
        if (err !== 1'b0) $display("[TB] FAIL b2b_err_cleared: got %b required 0", err);
        else passed++;
        for (int k = 1; k <= 12; k++) begin
            tick();
            done_mask[k] = done;
            if (k == 6) req = 1'b0;
        end
        checks++;
        if (done_mask !== 13'b0_1000_0010_0000)
            $display("[TB] FAIL b2b_done_mask: got %b required 0100000100000", done_mask);
        else passed++;
        req = 1'b1;
        tick();
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (done) begin
                done_count++;
                req = 1'b0;
            end
            if (k >= 6 && !AS_n) as_low = 1'b1;
        end
        checks++;
        if ({done_count, as_low} !== {32'd1, 1'b0})
            $display("[TB] FAIL b2b_drop_req: got %0d/%b required 1/0", done_count, as_low);
        else passed++;
    endtask

    task automatic test_grant();
        logic any_busy = 1'b0;
        int   done_k = -1;
        DTACK_n   = 1'b0;
        bus_grant = 1'b0;
        req_rw    = 1'b1;
        req_addr  = 23'h000400;
        req_ube   = 1'b1;
        req_lbe   = 1'b0;
        req       = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (busy || !AS_n) any_busy = 1'b1;
        end
        checks++;
        if (any_busy !== 1'b0) $display("[TB] FAIL grant_blocked: got %b required 0", any_busy);
        else passed++;
        bus_grant = 1'b1;
        tick();
        req       = 1'b0;
        bus_grant = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (done && done_k < 0) done_k = k;
        end
        checks++;
        if (done_k !== 5) $display("[TB] FAIL grant_loss_done: got %0d required 5", done_k);
        else passed++;
        bus_grant = 1'b1;
    endtask

    task automatic test_withheld();
        int   done_k = -1;
        logic err_at_done = 1'b0;
        DTACK_n = 1'b1;
        applyStimulus(1'b1, 23'h000500, 1'b1, 1'b1, 16'h0000);
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (done && done_k < 0) begin
                done_k      = k;
                err_at_done = err;
            end
        end
`ifdef ZORRO_MASTER_TIMEOUT_EN
        checks++;
        if (done_k !== 67) $display("[TB] FAIL timeout_done_cycle: got %0d required 67", done_k);
        else passed++;
        checks++;
        if (err_at_done !== 1'b1) $display("[TB] FAIL timeout_err: got %b required 1", err_at_done);
        else passed++;
`else
        checks++;
        if (done_k !== -1) $display("[TB] FAIL withheld_no_done: got %0d required -1", done_k);
        else passed++;
        checks++;
        if ({busy, AS_n, err_at_done} !== 3'b100)
            $display("[TB] FAIL withheld_busy: got %b required 100", {busy, AS_n, err_at_done});
        else passed++;
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        tick();
`endif
        DTACK_n = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic any_done = 1'b0;
        logic any_busy = 1'b0;
        DTACK_n = 1'b1;
        applyStimulus(1'b0, 23'h000600, 1'b1, 1'b1, 16'hBEEF);
        for (int k = 1; k <= 8; k++) tick();
        checks++;
        if ({AS_n, UDS_n, LDS_n, DOE} !== 4'b0001)
            $display("[TB] FAIL mid_in_wait: got %b required 0001", {AS_n, UDS_n, LDS_n, DOE});
        else passed++;
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        checks++;
        if ({AS_n, UDS_n, LDS_n, DOE, busy, done} !== 6'b111000)
            $display("[TB] FAIL mid_reset_pins: got %b required 111000",
                     {AS_n, UDS_n, LDS_n, DOE, busy, done});
        else passed++;
        DTACK_n = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (done) any_done = 1'b1;
            if (busy) any_busy = 1'b1;
        end
        checks++;
        if ({any_done, any_busy} !== 2'b00)
            $display("[TB] FAIL mid_reset_quiet: got %b required 00", {any_done, any_busy});
        else passed++;
    endtask

    initial begin
        RESET     = 1'b1;
        req       = 1'b0;
        req_addr  = '0;
        req_rw    = 1'b1;
        req_ube   = 1'b0;
        req_lbe   = 1'b0;
        req_wdata = '0;
        bus_grant = 1'b1;
        DIN       = '0;
        DTACK_n   = 1'b1;
        BERR_n    = 1'b1;
        $display("[TB] starting zorro_master bench");
        test_reset();
        test_read();
        test_write();
        test_berr();
        test_no_enables();
        test_back_to_back();
        test_grant();
        test_withheld();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
